// File: rtl/skid_buffer_pkg.sv
// Shared types and reset constants for the two-entry skid buffer.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam skid_state_t RST_STATE     = EMPTY;
  localparam logic        RST_IN_READY  = 1'b1;
  localparam logic        RST_OUT_VALID = 1'b0;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready slice with a registered in_ready, cutting the backward timing path.
// Optional saturating stall counter enabled by defining SKID_BUFFER_STATS_EN.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
`ifdef SKID_BUFFER_STATS_EN
  ,parameter int unsigned STAT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SKID_BUFFER_STATS_EN
  ,output logic [STAT_WIDTH-1:0] stall_cycles
`endif
);

  skid_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  push, pop;

  // Next-state and storage steering; handshake flags are decoded from the next state.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    push        = in_valid && in_ready_q;
    pop         = out_valid_q && out_ready;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= RST_IN_READY;
      out_valid_q <= RST_OUT_VALID;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef SKID_BUFFER_STATS_EN
  logic [STAT_WIDTH-1:0] stall_q, stall_d;

  // Counts cycles where data is offered but not taken; sticks at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !out_ready && (stall_q != {STAT_WIDTH{1'b1}})) begin
      stall_d = stall_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
Two-entry valid/ready register slice that breaks the backward path: in_ready comes directly from a flop, so upstream never sees combinational out_ready. It pairs with pipelined_register, which registers only the forward path (data/valid) and passes ready through combinationally. Chaining the two gives full timing isolation on long stream interconnects. Sustains 1 transfer/cycle with FIFO ordering.

Parameters:
DATA_WIDTH, 32, width of in_data/out_data
STAT_WIDTH, 16, width of stall counter (used only when SKID_BUFFER_STATS_EN is defined)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
in_data  input  DATA_WIDTH  upstream payload
in_valid  input  1  upstream payload valid
in_ready  output  1  registered; buffer can accept this cycle
out_data  output  DATA_WIDTH  payload from main register
out_valid  output  1  main register holds data
out_ready  input  1  downstream accepts
stall_cycles  output  STAT_WIDTH  saturating stall count (present only with SKID_BUFFER_STATS_EN)

Behaviour:
- Definitions: push = in_valid && in_ready; pop = out_valid && out_ready.
- Storage: main register (drives out_data) and skid register.
- State is one of EMPTY, BUSY, FULL. Reset value is EMPTY.
- Reset (rst_n low at clk edge, synchronous): state EMPTY, in_ready=1, out_valid=0, out_data=0, skid=0, stall_cycles=0.
- Reset mid-operation discards both entries. No output changes until the edge that samples rst_n low.
- Outputs per state:
  - EMPTY: out_valid=0, in_ready=1.
  - BUSY: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- in_ready and out_valid are flop outputs. Neither has a combinational path from any input.
- Transitions from EMPTY:
  - push: main<=in_data, go to BUSY.
  - otherwise: stay.
- Transitions from BUSY:
  - push && pop: main<=in_data, stay BUSY.
  - push && !pop: skid<=in_data, go to FULL.
  - !push && pop: go to EMPTY.
  - neither: hold.
- Transitions from FULL:
  - pop: main<=skid, go to BUSY.
  - otherwise: hold.
  - push is impossible in FULL; in_valid is ignored.
- Latency: data accepted at edge N appears on out_data after edge N (one cycle) when the buffer was EMPTY or drained that cycle.
- Throughput: 1 beat/cycle with out_ready held high. Zero bubbles at steady state.
- Output stability (AXI-style): while out_valid && !out_ready, out_data and out_valid must not change.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- Upstream must hold in_data stable while in_valid && !in_ready. The block does not check this.

Optional Feature:
- Macro SKID_BUFFER_STATS_EN.
- Defined:
  - stall_cycles port exists.
  - It increments each cycle out_valid && !out_ready.
  - It saturates at all-ones and does not wrap.
  - Synchronous reset clears it to 0.
- Undefined: the port and counter logic are absent. Datapath behaviour is identical in both builds.

Decomposition:
- Package skid_buffer_pkg holds:
  - typedef enum logic [1:0] skid_state_t {EMPTY, BUSY, FULL};
  - the reset-value constants.
- No sub-module: main register, skid register and the 3-state FSM stay flat in one module.
- The stall counter lives inline under the macro guard.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, in_ready=1, out_data=0 after the edge; no data captured.
2. Streaming: out_ready=1, push 0x1..0x8 back-to-back -> out_data shows 0x1..0x8 on consecutive cycles starting 1 cycle later; in_ready stays 1; no bubbles.
3. Backpressure: push 0xA,0xB with out_ready=0 -> cycle after 0xB in_ready=0 (FULL), out_data=0xA held; raise out_ready -> 0xA, then 0xB, in_ready returns to 1 the cycle after the first pop.
4. Random: random in_valid/out_ready at 50% over 10,000 beats -> scoreboard shows exact FIFO order; out_data stable while stalled; in_ready never 1 in FULL.
5. Reset mid-operation: FULL with 0x11/0x22, assert rst_n=0 one cycle -> out_valid=0, in_ready=1; 0x11 and 0x22 never appear afterward.
6. SKID_BUFFER_STATS_EN with STAT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles reaches 15 and holds 15; without the macro the build elaborates with no stall_cycles port.
